// File: rtl/run_controller.sv
// Run/halt/single-step controller for a CPU core with a debounced step button.
// Optional breakpoint logic is compiled in when RUN_CTRL_BREAKPOINT_EN is defined.
module run_controller #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_btn,
    input  logic             run_sw,
    input  logic [31:0]      pc,
    input  logic [31:0]      bp_addr,
    input  logic             bp_valid,
    output logic             cpu_en,
    output logic             halted,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_STEP  = 2'b01,
        ST_RUN   = 2'b10,
        ST_BREAK = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              db_level_q, db_level_d;
    logic              step_pulse_q, step_pulse_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              bp_hit_s;
    logic              cpu_en_s;

`ifdef RUN_CTRL_BREAKPOINT_EN
    assign bp_hit_s = bp_valid && (pc == bp_addr) && (state_q == ST_RUN);
`else
    logic unused_bp_s;
    assign unused_bp_s = ^{pc, bp_addr, bp_valid};
    assign bp_hit_s    = 1'b0;
`endif

    // A breakpointed instruction is held off in the hit cycle itself.
    assign cpu_en_s = (state_q == ST_STEP) || ((state_q == ST_RUN) && !bp_hit_s);

    // Synchronizer, debounce counter and rising-edge pulse of the debounced level.
    always_comb begin
        sync1_d      = step_btn;
        sync2_d      = sync1_q;
        db_cnt_d     = db_cnt_q;
        db_level_d   = db_level_q;
        step_pulse_d = 1'b0;
        if (sync2_q == db_level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt_d     = '0;
            db_level_d   = sync2_q;
            step_pulse_d = sync2_q;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    // Next-state logic; a step pulse seen in STEP or RUN is simply dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HALT: begin
                if (run_sw) begin
                    state_d = ST_RUN;
                end else if (step_pulse_q) begin
                    state_d = ST_STEP;
                end else begin
                    state_d = ST_HALT;
                end
            end
            ST_STEP: begin
                if (run_sw) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HALT;
                end
            end
            ST_RUN: begin
                if (!run_sw) begin
                    state_d = ST_HALT;
                end else if (bp_hit_s) begin
                    state_d = ST_BREAK;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_BREAK: begin
                if (step_pulse_q) begin
                    state_d = ST_STEP;
                end else if (!run_sw) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_BREAK;
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    // Executed-instruction counter, wrapping naturally at CNT_W bits.
    always_comb begin
        if (cpu_en_s) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_HALT;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            db_cnt_q     <= '0;
            db_level_q   <= 1'b0;
            step_pulse_q <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            db_cnt_q     <= db_cnt_d;
            db_level_q   <= db_level_d;
            step_pulse_q <= step_pulse_d;
            count_q      <= count_d;
        end
    end

    assign cpu_en      = cpu_en_s;
    assign halted      = !cpu_en_s && (state_q != ST_STEP);
    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_run_controller.sv
// Randomized + directed bench for run_controller against a queue-based reference model.
module tb_run_controller;

    localparam int DEB = 16;
    localparam int M_HALT = 0, M_STEP = 1, M_RUN = 2, M_BREAK = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        step_btn = 1'b0;
    logic        run_sw = 1'b0;
    logic [31:0] pc = 32'd0;
    logic [31:0] bp_addr = 32'd16;
    logic        bp_valid = 1'b0;
    logic        cpu_en, halted, cpu_en4, halted4;
    logic [1:0]  state, state4;
    logic [31:0] instr_count;
    logic [3:0]  instr_count4;

    run_controller #(.DEBOUNCE_CYCLES(DEB), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .step_btn(step_btn), .run_sw(run_sw), .pc(pc),
        .bp_addr(bp_addr), .bp_valid(bp_valid), .cpu_en(cpu_en), .halted(halted),
        .state(state), .instr_count(instr_count));

    run_controller #(.DEBOUNCE_CYCLES(DEB), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .step_btn(step_btn), .run_sw(run_sw), .pc(pc),
        .bp_addr(bp_addr), .bp_valid(bp_valid), .cpu_en(cpu_en4), .halted(halted4),
        .state(state4), .instr_count(instr_count4));

    always #5 clk = ~clk;

    int chk_cnt = 0;
    int err_cnt = 0;
    int en_seen = 0;

    // Reference model: synchronizer samples, history of the last DEB samples, abstract state.
    bit          m_s1, m_s2, m_level, m_pulse;
    bit          hist[$];
    int          m_state;
    logic [31:0] m_count;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_hit();
`ifdef RUN_CTRL_BREAKPOINT_EN
        return bp_valid && (pc == bp_addr) && (m_state == M_RUN);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_en();
        return (m_state == M_STEP) || (m_state == M_RUN && !m_hit());
    endfunction

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_level = 0; m_pulse = 0;
        hist.delete();
        m_state = M_HALT;
        m_count = 32'd0;
    endtask

    // Applies one rising edge to the model using the inputs currently driven.
    task automatic model_edge();
        bit samp, all_same, npulse;
        int nstate;
        if (rst) begin
            model_reset();
            return;
        end
        samp = m_s2;
        hist.push_back(samp);
        if (hist.size() > DEB) void'(hist.pop_front());
        npulse = 0;
        if (hist.size() == DEB) begin
            all_same = 1;
            foreach (hist[i]) if (hist[i] != samp) all_same = 0;
            if (all_same && samp != m_level) begin
                m_level = samp;
                npulse  = samp;
            end
        end
        if (m_en()) m_count = m_count + 32'd1;
        case (m_state)
            M_HALT:  nstate = run_sw ? M_RUN : (m_pulse ? M_STEP : M_HALT);
            M_STEP:  nstate = run_sw ? M_RUN : M_HALT;
            M_RUN:   nstate = !run_sw ? M_HALT : (m_hit() ? M_BREAK : M_RUN);
            default: nstate = m_pulse ? M_STEP : (!run_sw ? M_HALT : M_BREAK);
        endcase
        m_state = nstate;
        m_s2 = m_s1;
        m_s1 = step_btn;
        m_pulse = npulse;
    endtask

    // One clock cycle: compare outputs for the driven inputs, then advance DUT and model.
    task automatic step_cycle();
        #1;
        check_eq("state", state, m_state);
        check_eq("cpu_en", cpu_en, m_en());
        check_eq("halted", halted, !m_en() && m_state != M_STEP);
        check_eq("instr_count", instr_count, m_count);
        check_eq("instr_count4", instr_count4, m_count[3:0]);
        if (cpu_en === 1'b1) en_seen++;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; step_btn = 1'b0; run_sw = 1'b0; pc = 32'd0;
        step_cycle();
        rst = 1'b0;
        en_seen = 0;
    endtask

    initial begin
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        step_cycle();
        check_eq("rst_state", state, 2'b00);
        check_eq("rst_cpu_en", cpu_en, 1'b0);
        check_eq("rst_halted", halted, 1'b1);
        check_eq("rst_count", instr_count, 32'd0);
        rst = 1'b0;

        // Clean press held 20 cycles gives exactly one step.
        do_reset();
        step_btn = 1'b1;
        repeat (20) step_cycle();
        step_btn = 1'b0;
        repeat (40) step_cycle();
        check_eq("press_en_cycles", en_seen, 1);
        check_eq("press_count", instr_count, 32'd1);
        check_eq("press_state", state, 2'b00);

        // Bouncing every 3 cycles never settles.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            step_btn = ((i / 3) % 2) == 1;
            step_cycle();
        end
        step_btn = 1'b0;
        repeat (30) step_cycle();
        check_eq("bounce_en_cycles", en_seen, 0);
        check_eq("bounce_count", instr_count, 32'd0);

        // Press interrupted by reset mid-debounce produces no step.
        do_reset();
        step_btn = 1'b1;
        repeat (12) step_cycle();
        rst = 1'b1; step_btn = 1'b0;
        step_cycle();
        rst = 1'b0;
        repeat (30) step_cycle();
        check_eq("rst_mid_db_count", instr_count, 32'd0);

        // Free run for 10 cycles.
        do_reset();
        run_sw = 1'b1;
        repeat (10) step_cycle();
        run_sw = 1'b0;
        repeat (3) step_cycle();
        check_eq("run10_en_cycles", en_seen, 10);
        check_eq("run10_count", instr_count, 32'd10);
        check_eq("run10_state", state, 2'b00);

        // Reset while running with count 7.
        do_reset();
        run_sw = 1'b1;
        repeat (8) step_cycle();
        check_eq("pre_rst_count", instr_count, 32'd7);
        check_eq("pre_rst_state", state, 2'b10);
        rst = 1'b1;
        step_cycle();
        #1;
        check_eq("post_rst_state", state, 2'b00);
        check_eq("post_rst_count", instr_count, 32'd0);
        check_eq("post_rst_cpu_en", cpu_en, 1'b0);
        rst = 1'b0; run_sw = 1'b0;
        step_cycle();

        // 17 executed cycles wrap a 4-bit counter to 1.
        do_reset();
        run_sw = 1'b1;
        repeat (17) step_cycle();
        run_sw = 1'b0;
        repeat (2) step_cycle();
        check_eq("wrap_count32", instr_count, 32'd17);
        check_eq("wrap_count4", instr_count4, 4'd1);

`ifdef RUN_CTRL_BREAKPOINT_EN
        // Breakpoint at 0x10 with a PC that advances on each executed cycle.
        do_reset();
        bp_addr = 32'h10; bp_valid = 1'b1; run_sw = 1'b1; pc = 32'd0;
        for (int i = 0; i < 12; i++) begin
            if (m_en()) begin
                step_cycle();
                pc = pc + 32'd4;
            end else begin
                step_cycle();
            end
        end
        check_eq("bp_pc", pc, 32'h10);
        check_eq("bp_state", state, 2'b11);
        check_eq("bp_count", instr_count, 32'd4);
        check_eq("bp_cpu_en", cpu_en, 1'b0);
        step_btn = 1'b1;
        begin
            int guard = 0;
            while (m_state != M_STEP && guard < 100) begin
                step_cycle();
                guard++;
            end
            check_eq("bp_step_reached", guard < 100, 1'b1);
        end
        run_sw = 1'b0;
        step_cycle();
        pc = pc + 32'd4;
        step_btn = 1'b0;
        repeat (30) step_cycle();
        check_eq("bp_step_count", instr_count, 32'd5);
        check_eq("bp_step_state", state, 2'b00);
        bp_valid = 1'b0;
`endif

        // Randomized operation against the model.
        do_reset();
        bp_addr = 32'd16;
        begin
            int hold = 0;
            for (int i = 0; i < 4000; i++) begin
                if (hold == 0) begin
                    step_btn = ~step_btn;
                    hold = $urandom_range(1, 40);
                end else begin
                    hold--;
                end
                if ($urandom_range(0, 99) < 3) run_sw = ~run_sw;
                pc       = 32'($urandom_range(0, 5)) * 32'd4;
                bp_valid = $urandom_range(0, 3) != 0;
                rst      = $urandom_range(0, 299) == 0;
                step_cycle();
            end
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
